// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WR_BUSY = 2'd1,
    ARB_RD_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational request picker: round-robin from a start pointer, or fixed priority
// (lowest index wins) when RISCV_MEM_ARB_PRIO_EN is defined.
module riscv_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

`ifdef RISCV_MEM_ARB_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Scan downwards so the lowest requesting index is the last one written.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_gnt = NUM_REQ'(1) << k;
        o_idx = IDX_W'(k);
      end
    end
  end
`else
  int unsigned      w_cand;
  logic [IDX_W-1:0] w_c;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    w_c     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = 32'(i_ptr) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      w_c = w_cand[IDX_W-1:0];
      if (!w_found && i_req[w_c]) begin
        w_found    = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one axil_if request port between NUM_REQ requesters, one transaction at a time.
// Define RISCV_MEM_ARB_PRIO_EN for fixed priority instead of round-robin.
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            i_req_wr_valid,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] i_req_wr_strb,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
  input  logic [NUM_REQ-1:0]            i_req_rd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_wr_ready,
  output logic [NUM_REQ-1:0]            o_req_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_req_rd_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_wr_valid,
  output logic [STRB_WIDTH-1:0]         o_wr_strb,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [ADDR_WIDTH-1:0]         o_wr_addr,
  input  logic                          i_wr_ready,
  output logic                          o_rd_ready,
  output logic [ADDR_WIDTH-1:0]         o_rd_addr,
  input  logic                          i_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_rd_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t r_state, w_state_nxt;

  logic [NUM_REQ-1:0]    r_gnt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_wr_valid;
  logic [STRB_WIDTH-1:0] r_wr_strb;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_rd_ready;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_start;
  logic               w_win_wr;
  logic               w_wr_done;
  logic               w_rd_done;

  assign w_req     = i_req_wr_valid | i_req_rd_ready;
  assign w_start   = (r_state == ARB_IDLE) && enable && (|w_req);
  // A requester holding both wr and rd gets its write served first.
  assign w_win_wr  = i_req_wr_valid[w_idx];
  assign w_wr_done = (r_state == ARB_WR_BUSY) && i_wr_ready;
  assign w_rd_done = (r_state == ARB_RD_BUSY) && i_rd_valid;

  riscv_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= ARB_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:    if (w_start) w_state_nxt = w_win_wr ? ARB_WR_BUSY : ARB_RD_BUSY;
      ARB_WR_BUSY: if (i_wr_ready) w_state_nxt = ARB_IDLE;
      ARB_RD_BUSY: if (i_rd_valid) w_state_nxt = ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_req_wr_ready = '0;
    o_req_rd_valid = '0;
    o_req_rd_data  = '0;
    if (w_wr_done) o_req_wr_ready = r_gnt;
    if (w_rd_done) begin
      o_req_rd_valid = r_gnt;
      o_req_rd_data  = i_rd_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_gnt      <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_wr_valid <= 1'b0;
      r_wr_strb  <= '0;
      r_wr_data  <= '0;
      r_wr_addr  <= '0;
      r_rd_ready <= 1'b0;
      r_rd_addr  <= '0;
    end else if (w_start) begin
      r_gnt      <= w_gnt;
      r_idx      <= w_idx;
      r_wr_valid <= w_win_wr;
      r_rd_ready <= !w_win_wr;
      r_wr_strb  <= i_req_wr_strb[w_idx*STRB_WIDTH +: STRB_WIDTH];
      r_wr_data  <= i_req_wr_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
      if (w_win_wr) r_wr_addr <= i_req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      else          r_rd_addr <= i_req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end else if (w_wr_done || w_rd_done) begin
      r_gnt      <= '0;
      r_wr_valid <= 1'b0;
      r_rd_ready <= 1'b0;
      r_ptr      <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_gnt      = r_gnt;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_strb  = r_wr_strb;
  assign o_wr_data  = r_wr_data;
  assign o_wr_addr  = r_wr_addr;
  assign o_rd_ready = r_rd_ready;
  assign o_rd_addr  = r_rd_addr;

endmodule
